// File: rtl/stopwatch_seq.sv
// BCD stopwatch sequencer: walks one shared CSA incrementer across the digits, one per clock.
// Optional lap/freeze display enabled by defining STOPWATCH_LAP_EN.

// Carry-select adder: low half ripples, high half is precomputed for both carry-ins.
module CSA #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);
    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic [LO:0] lo_s;
    logic [HI:0] hi0;
    logic [HI:0] hi1;

    assign lo_s = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, ci};
    assign hi0  = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
    assign hi1  = hi0 + {{HI{1'b0}}, 1'b1};
    assign sum  = {(lo_s[LO] ? hi1[HI-1:0] : hi0[HI-1:0]), lo_s[LO-1:0]};
    assign co   = lo_s[LO] ? hi1[HI] : hi0[HI];
endmodule

module stopwatch_seq #(
    parameter int DIGITS  = 4,
    parameter int TOP_MOD = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                start_stop,
    input  logic                clear,
    input  logic                lap,
    output logic [4*DIGITS-1:0] time_bcd,
    output logic                running,
    output logic                busy,
    output logic                wrap,
    output logic                missed_tick
`ifdef STOPWATCH_LAP_EN
    ,
    output logic                lap_active
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

    state_t                    state, state_n;
    logic                      run_flag, run_n;
    logic                      pending, pend_n;
    logic                      miss_n;
    logic                      wrap_n;
    logic                      seq_done;
    logic [IW-1:0]             idx, idx_n;
    logic [DIGITS-1:0][3:0]    dig, dig_n;
    logic [3:0]                cur, r, modv;
    logic                      unused_co;

    assign cur  = dig[idx];
    assign modv = (idx == LAST) ? 4'(TOP_MOD) : 4'd10;

    CSA #(.W(4)) u_inc (
        .a   (cur),
        .b   (4'b0),
        .ci  (1'b1),
        .sum (r),
        .co  (unused_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            run_flag    <= 1'b0;
            pending     <= 1'b0;
            missed_tick <= 1'b0;
            wrap        <= 1'b0;
            idx         <= '0;
            dig         <= '0;
        end else begin
            state       <= state_n;
            run_flag    <= run_n;
            pending     <= pend_n;
            missed_tick <= miss_n;
            wrap        <= wrap_n;
            idx         <= idx_n;
            dig         <= dig_n;
        end
    end

    always_comb begin
        state_n  = state;
        run_n    = run_flag ^ start_stop;
        pend_n   = pending;
        miss_n   = missed_tick;
        wrap_n   = 1'b0;
        idx_n    = idx;
        dig_n    = dig;
        seq_done = 1'b0;
        if (clear) begin
            dig_n   = '0;
            pend_n  = 1'b0;
            miss_n  = 1'b0;
            idx_n   = '0;
            state_n = run_n ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: if (run_n) state_n = RUN;
                RUN: begin
                    if (!run_n) state_n = IDLE;
                    else if (tick) begin
                        state_n = STEP;
                        idx_n   = '0;
                    end
                end
                STEP: begin
                    if (tick) begin
                        if (pending) miss_n = 1'b1;
                        pend_n = 1'b1;
                    end
                    if (r == modv) begin
                        dig_n[idx] = 4'd0;
                        if (idx != LAST) idx_n = idx + 1'b1;
                        else begin
                            wrap_n   = 1'b1;
                            seq_done = 1'b1;
                        end
                    end else begin
                        dig_n[idx] = r;
                        seq_done   = 1'b1;
                    end
                    // A tick landing on the final write cycle still counts as pending.
                    if (seq_done) begin
                        idx_n  = '0;
                        pend_n = 1'b0;
                        if (run_n && (pending || tick)) state_n = STEP;
                        else                            state_n = run_n ? RUN : IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy    = (state == STEP);
    assign running = (state != IDLE);

`ifdef STOPWATCH_LAP_EN
    logic [4*DIGITS-1:0] lap_hold;
    logic                lap_on;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_on   <= 1'b0;
            lap_hold <= '0;
        end else if (clear) begin
            lap_on <= 1'b0;
        end else if (lap) begin
            lap_on <= !lap_on;
            if (!lap_on) lap_hold <= dig;
        end
    end

    assign time_bcd   = lap_on ? lap_hold : dig;
    assign lap_active = lap_on;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign time_bcd   = dig;
`endif
endmodule

// File: tb/tb_stopwatch_seq.sv
// Bench for stopwatch_seq: integer-count reference model, per-cycle compare, directed + random stimulus.
module tb_stopwatch_seq;
    localparam int DIGITS = 4;
    localparam int MAXC   = 6000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [15:0] time_bcd;
    logic        running, busy, wrap, missed_tick;
`ifdef STOPWATCH_LAP_EN
    logic        lap_active;
`endif

    stopwatch_seq #(.DIGITS(DIGITS), .TOP_MOD(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .start_stop  (start_stop),
        .clear       (clear),
        .lap         (lap),
        .time_bcd    (time_bcd),
        .running     (running),
        .busy        (busy),
        .wrap        (wrap),
        .missed_tick (missed_tick)
`ifdef STOPWATCH_LAP_EN
        ,
        .lap_active  (lap_active)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int busy_cnt = 0;
    int wrap_cnt = 0;

    // Reference model: time as a plain integer count of hundredths.
    int          m_count = 0, m_k = 0, m_len = 0;
    bit          m_run = 0, m_seq = 0, m_pend = 0, m_miss = 0, m_wrap = 0;
    bit          m_lap = 0;
    logic [15:0] m_hold = '0;

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int c);
        logic [15:0] b = '0;
        for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'((c / pow10(i)) % 10);
        return b;
    endfunction

    // Cycles needed: one per trailing 9 plus the final non-rolling digit (capped at DIGITS).
    function automatic int seq_len(input int c);
        int k = 1;
        while (k < DIGITS && ((c / pow10(k - 1)) % 10) == 9) k++;
        return k;
    endfunction

    function automatic logic [15:0] live_bcd();
        if (m_seq) return to_bcd(m_count - (m_count % pow10(m_k)));
        return to_bcd(m_count);
    endfunction

    task automatic m_start();
        m_seq = 1;
        m_k   = 0;
        m_len = seq_len(m_count);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_count = 0; m_k = 0; m_len = 0;
            m_run = 0; m_seq = 0; m_pend = 0; m_miss = 0; m_wrap = 0;
            m_lap = 0; m_hold = '0;
        end else begin
            logic [15:0] live_pre;
            bit          nrun;
            live_pre = live_bcd();
            nrun     = m_run ^ start_stop;
            m_wrap   = 0;
`ifdef STOPWATCH_LAP_EN
            if (clear) m_lap = 0;
            else if (lap) begin
                if (!m_lap) m_hold = live_pre;
                m_lap = !m_lap;
            end
`endif
            if (clear) begin
                m_count = 0; m_seq = 0; m_pend = 0; m_miss = 0;
            end else if (m_seq) begin
                if (tick) begin
                    if (m_pend) m_miss = 1;
                    m_pend = 1;
                end
                m_k++;
                if (m_k == m_len) begin
                    m_wrap  = (m_count == MAXC - 1);
                    m_count = (m_count + 1) % MAXC;
                    m_seq   = 0;
                    if (nrun && m_pend) m_start();
                    m_pend  = 0;
                end
            end else if (m_run && nrun && tick) begin
                m_start();
            end
            m_run = nrun;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            logic [15:0] e_time;
            e_time = m_lap ? m_hold : live_bcd();
            if (busy) busy_cnt++;
            if (wrap) wrap_cnt++;
            tests++;
            if (time_bcd !== e_time || running !== (m_run | m_seq) || busy !== m_seq ||
                wrap !== m_wrap || missed_tick !== m_miss
`ifdef STOPWATCH_LAP_EN
                || lap_active !== m_lap
`endif
                ) begin
                fails++;
                $display("FAIL cycle t=%0t got time=%h run=%b busy=%b wrap=%b miss=%b exp time=%h run=%b busy=%b wrap=%b miss=%b",
                         $time, time_bcd, running, busy, wrap, missed_tick,
                         e_time, m_run | m_seq, m_seq, m_wrap, m_miss);
                if (fails >= 50) begin
                    $display("[TB] %0d tests run, %0d failed", tests, fails);
                    $finish;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; step(); start_stop = 1'b0;
    endtask

    initial begin
        step(); step();
        chk("reset_time", 32'(time_bcd), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        step();
        chk("idle_running", 32'(running), 32'h0);

        // Ticks while idle are ignored and not counted as missed.
        ticks(3, 2);
        chk("idle_tick_time", 32'(time_bcd), 32'h0);

        pulse_ss();
        busy_cnt = 0;
        ticks(7, 10);
        chk("t1_time", 32'(time_bcd), 32'h0007);
        chk("t1_running", 32'(running), 32'h1);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd7);

        ticks(2, 5);
        busy_cnt = 0;
        ticks(1, 5);
        chk("t2_time", 32'(time_bcd), 32'h0010);
        chk("t2_busy_cycles", 32'(busy_cnt), 32'd2);

        ticks(5989, 5);
        chk("t3_max", 32'(time_bcd), 32'h5999);
        busy_cnt = 0; wrap_cnt = 0;
        ticks(1, 6);
        chk("t3_wrap_time", 32'(time_bcd), 32'h0000);
        chk("t3_wrap_cnt", 32'(wrap_cnt), 32'd1);
        chk("t3_busy_cycles", 32'(busy_cnt), 32'd4);

        ticks(99, 5);
        chk("t4_pre", 32'(time_bcd), 32'h0099);
        tick = 1'b1; repeat (3) step(); tick = 1'b0;
        repeat (10) step();
        chk("t4_time", 32'(time_bcd), 32'h0101);
        chk("t4_missed", 32'(missed_tick), 32'h1);

        ticks(898, 5);
        chk("t5_pre", 32'(time_bcd), 32'h0999);
        tick = 1'b1; step(); tick = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        chk("t5_clear_time", 32'(time_bcd), 32'h0000);
        chk("t5_clear_busy", 32'(busy), 32'h0);
        chk("t5_clear_missed", 32'(missed_tick), 32'h0);
        chk("t5_clear_running", 32'(running), 32'h1);
        ticks(9, 5);
        tick = 1'b1; step(); tick = 1'b0;
        pulse_ss();
        repeat (4) step();
        chk("t5_ss_time", 32'(time_bcd), 32'h0010);
        chk("t5_ss_running", 32'(running), 32'h0);

        pulse_ss();
        ticks(9, 5);
        tick = 1'b1; step(); tick = 1'b0;
        chk("t6_midstep_busy", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_time", 32'(time_bcd), 32'h0);
        chk("t6_rst_outs", {28'h0, running, busy, wrap, missed_tick}, 32'h0);
        step();
        reset_n = 1'b1;
        step();

`ifdef STOPWATCH_LAP_EN
        pulse_ss();
        ticks(12, 5);
        lap = 1'b1; step(); lap = 1'b0;
        ticks(30, 5);
        chk("lap_hold", 32'(time_bcd), 32'h0012);
        lap = 1'b1; step(); lap = 1'b0;
        chk("lap_release", 32'(time_bcd), 32'h0042);
`endif

        // Random phase: the per-cycle compare carries the checking here.
        pulse_ss();
        for (int i = 0; i < 6000; i++) begin
            tick       = ($urandom_range(99) < 35);
            start_stop = ($urandom_range(99) < 2);
            clear      = ($urandom_range(199) < 1);
            lap        = ($urandom_range(99) < 3);
            step();
        end
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stopwatch_seq.md
Name: stopwatch_seq

Overview:
Stopwatch timekeeping sequencer. Holds a BCD time value (default SS.cc, 4 digits) and advances it on each 100 Hz tick, using one shared 4-bit CSA instance (CSA #(4)) as the incrementer. It walks that adder across the digits one per clock, carrying into the next digit.
Sits between the tick divider and the 7-segment display driver. Also owns the run/stop/clear control state.

Parameters:
DIGITS, 4, number of BCD digits; digit 0 is least significant (hundredths).
TOP_MOD, 6, modulus of digit DIGITS-1 (tens of seconds); all lower digits use modulus 10.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
tick  input  1  single-cycle pulse at count rate (100 Hz).
start_stop  input  1  single-cycle pulse; toggles run state.
clear  input  1  single-cycle pulse; zeroes time.
lap  input  1  single-cycle pulse; used only when LAP_EN is defined.
time_bcd  output  4*DIGITS  displayed time, digit i at [4i+3:4i].
running  output  1  1 while in RUN state.
busy  output  1  1 while an increment is being sequenced.
wrap  output  1  one-cycle pulse when time rolls over from max to all zeros.
missed_tick  output  1  sticky; set when a tick is dropped; cleared only by clear or reset.

Behaviour:
- Reset (async, reset_n=0): all digits 0, state IDLE, running=0, busy=0, wrap=0, missed_tick=0, pending=0, index=0. Asynchronous reset also aborts any in-flight sequence.
- Adder usage: exactly one CSA #(4) instance.
  - a = digit[index], b = 4'b0, ci = 1.
  - sum is the incremented digit; co is ignored, because digits never exceed 9.
- States:
  - IDLE: not counting.
  - RUN: counting, waiting for a tick.
  - STEP: sequencing an increment.
- Run-state transitions:
  - IDLE → RUN on start_stop.
  - RUN → IDLE on start_stop.
  - A start_stop arriving in STEP toggles a run flag that takes effect when the sequence ends. An in-flight increment always completes.
- Tick handling:
  - RUN + tick → STEP with index=0, busy=1 in the next cycle.
  - Tick in IDLE is ignored and is not counted as missed.
- STEP, one digit per clock:
  - r = CSA sum.
  - If r == mod(index): digit[index] ← 0.
    - If index < DIGITS-1: index ← index+1 and stay in STEP.
    - If index == DIGITS-1: assert wrap for one cycle and exit STEP.
  - Otherwise: digit[index] ← r and exit STEP.
  - Exit target is RUN or IDLE according to the run flag.
  - Latency: 1 to DIGITS cycles from tick to final write. busy deasserts the cycle after the last write.
- Tick during STEP:
  - First such tick sets pending. On exit from STEP with pending=1 and run flag set, go directly back to STEP with index=0 and clear pending.
  - A tick while pending is already 1 is dropped and sets missed_tick.
  - If the sequence exits to IDLE, pending is cleared with no increment.
- clear (synchronous, highest priority after reset):
  - All digits ← 0, pending ← 0, missed_tick ← 0, index ← 0.
  - STEP is aborted to RUN or IDLE per the run flag. Run state is otherwise unchanged.
  - clear and tick in the same cycle: clear wins, the tick is discarded.
  - clear and start_stop in the same cycle: both take effect.
- Digit writes are glitch-free: time_bcd is registered, and each digit changes at most once per clock.
- Max value is TOP_MOD-1 followed by 9s (59.99 by default). The next increment gives all zeros plus a wrap pulse, and counting continues.

Optional Feature:
Macro STOPWATCH_LAP_EN.
- Defined:
  - lap pulse freezes time_bcd at its current value while the internal count keeps advancing.
  - A second lap pulse releases the freeze; time_bcd shows the live count from the next cycle.
  - clear also releases the freeze.
  - An additional output lap_active (1 bit, reset 0) is present.
- Not defined: the lap port is ignored, there is no lap_active port, and time_bcd always equals the live digits.

Test Plan:
1. Reset, then start_stop, then 7 ticks spaced 10 clocks apart → time_bcd=16'h0007, running=1, busy for 1 cycle per tick.
2. Preload via 9 ticks, then 1 tick → digit0 0, digit1 1 (16'h0010). busy high 2 cycles.
3. Run 5999 ticks, then 1 more → 16'h5999 then 16'h0000. wrap pulses once. busy high 4 cycles on the last tick.
4. At 16'h0099, tick then a second tick 1 clock later, then a third 1 clock after that → second tick pending, third dropped. Final 16'h0101, missed_tick=1.
5. At 16'h0999, clear asserted in the cycle after the triggering tick (mid-STEP) → 16'h0000 next cycle, busy=0, missed_tick=0, running still 1. Also: start_stop mid-STEP → increment completes, then running=0.
6. reset_n pulsed low asynchronously mid-STEP → all outputs at reset values immediately. With STOPWATCH_LAP_EN: lap at 16'h0012 plus 30 ticks → display holds 0012 while the count reaches 0042; second lap → display 0042.
